// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcodes and arbiter FSM states.
// Imported by the request arbiter slice.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 3;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BEQ = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: two requester handshakes plus the response port.
// slave = arbiter side, master = pipeline side.
interface alu_req_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_r;
  logic              rsp_zero;
  logic              rsp_ovf;
  logic              rsp_branch;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_r,
    output rsp_zero, rsp_ovf, rsp_branch,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_r,
    input  rsp_zero, rsp_ovf, rsp_branch,
    output rsp_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant with a last-grant register.
// Reset leaves last=1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_id,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt_id = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt_id = ~last;
      (req == 2'b10): gnt_id = 1'b1;
      default:        gnt_id = 1'b0;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (en && |req)
      gnt = gnt_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset)
      last <= 1'b1;
    else if (|gnt)
      last <= gnt_id;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered ALU between EX and branch unit.
// Round-robin accept, operand issue, and a held, id-tagged response.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  alu_req_arbiter_if.slave  bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic              alu_branch,
  output logic              busy
);

  arb_state_t state;
  arb_state_t nxt;

  logic       window;
  logic       accept;
  logic       gnt_id;
  logic [1:0] gnt;
  logic       pend_id;

  logic              rv;
  logic              rid;
  logic [DATA_W-1:0] rr;
  logic              rz;
  logic              ro;
  logic              rb;

  // Never accept while reset is high: the op would be dropped silently.
  assign window = !reset &&
                  ((state == ST_IDLE) ||
                   (state == ST_RESP && bus.rsp_ready));

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .en     (window),
    .gnt_id (gnt_id),
    .gnt    (gnt)
  );

  assign accept         = |gnt;
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign busy           = (state != ST_IDLE);

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) nxt = ST_ISSUE;
      ST_ISSUE: nxt = ST_CAPT;
      ST_CAPT:  nxt = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready)
          nxt = accept ? ST_ISSUE : ST_IDLE;
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      pend_id  <= 1'b0;
    end else if (accept) begin
      alu_a    <= gnt_id ? bus.req1_a  : bus.req0_a;
      alu_b    <= gnt_id ? bus.req1_b  : bus.req0_b;
      alu_ctrl <= gnt_id ? bus.req1_op : bus.req0_op;
      pend_id  <= gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rv  <= 1'b0;
      rid <= 1'b0;
      rr  <= '0;
      rz  <= 1'b0;
      ro  <= 1'b0;
      rb  <= 1'b0;
    end else if (state == ST_CAPT) begin
      rv  <= 1'b1;
      rid <= pend_id;
      rr  <= alu_r;
      rz  <= alu_zero;
      ro  <= alu_ovf;
      rb  <= alu_branch;
    end else if (rv && bus.rsp_ready) begin
      rv  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rv;
  assign bus.rsp_id     = rid;
  assign bus.rsp_r      = rr;
  assign bus.rsp_zero   = rz;
  assign bus.rsp_ovf    = ro;
  assign bus.rsp_branch = rb;

endmodule
